// File: rtl/sync_fifo_flagged.sv
// Single-clock FIFO with occupancy level, almost-full/almost-empty thresholds, sticky overflow/underflow and flush.
// Define FIFO_FWFT_EN for first-word fall-through reads; otherwise read_data is registered on each accepted pop.
module sync_fifo_flagged #(
    parameter int DATA_WIDTH         = 4,
    parameter int ADDRESS_WIDTH      = 5,
    parameter int ALMOST_FULL_LEVEL  = 28,
    parameter int ALMOST_EMPTY_LEVEL = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     flag_clear,
    input  logic [DATA_WIDTH-1:0]    write_data,
    input  logic                     write_increment,
    output logic                     full,
    output logic                     almost_full,
    output logic                     overflow,
    input  logic                     read_increment,
    output logic [DATA_WIDTH-1:0]    read_data,
    output logic                     empty,
    output logic                     almost_empty,
    output logic                     underflow,
    output logic [ADDRESS_WIDTH:0]   level
);

    localparam int DEPTH = 1 << ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH:0] DEPTH_LEVEL = (ADDRESS_WIDTH+1)'(DEPTH);
    localparam logic [ADDRESS_WIDTH:0] AF_LEVEL    = (ADDRESS_WIDTH+1)'(ALMOST_FULL_LEVEL);
    localparam logic [ADDRESS_WIDTH:0] AE_LEVEL    = (ADDRESS_WIDTH+1)'(ALMOST_EMPTY_LEVEL);

    logic [DATA_WIDTH-1:0]  mem [DEPTH];
    logic [ADDRESS_WIDTH:0] wptr;
    logic [ADDRESS_WIDTH:0] rptr;
    logic                   push_ok;
    logic                   pop_ok;

    // The extra pointer bit makes level a plain modular difference, so full and empty stay distinct.
    assign level        = wptr - rptr;
    assign full         = (level == DEPTH_LEVEL);
    assign empty        = (level == '0);
    assign almost_full  = (level >= AF_LEVEL);
    assign almost_empty = (level <= AE_LEVEL);

    assign push_ok = write_increment && !full;
    assign pop_ok  = read_increment && !empty;

    always_ff @(posedge clk) begin
        if (rst_n && !flush && push_ok) begin
            mem[wptr[ADDRESS_WIDTH-1:0]] <= write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop_ok)  rptr <= rptr + 1'b1;
        end
    end

    // A violation in the same cycle as flag_clear wins; flush leaves the sticky flags alone.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (!flush) begin
            overflow  <= (overflow  && !flag_clear) || (write_increment && full);
            underflow <= (underflow && !flag_clear) || (read_increment && empty);
        end
    end

`ifdef FIFO_FWFT_EN
    assign read_data = mem[rptr[ADDRESS_WIDTH-1:0]];
`else
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            read_data <= '0;
        end else if (!flush && pop_ok) begin
            read_data <= mem[rptr[ADDRESS_WIDTH-1:0]];
        end
    end
`endif

endmodule
